// File: rtl/cpu_pkg.sv
// cpu_pkg: shared state encoding, opcode map and default widths for the 4-bit CPU control path
package cpu_pkg;
    localparam int INSTR_W_D = 8;
    localparam int OP_W_D    = 3;
    localparam int REG_AW_D  = 2;
    localparam int PC_W_D    = 4;
    localparam int CNT_W_D   = 8;
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        DECODE    = 3'd2,
        EXECUTE   = 3'd3,
        WRITEBACK = 3'd4,
        HALT      = 3'd5
    } state_e;
    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_MOV  = 3'b101;
    localparam logic [2:0] OP_JMP  = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;
endpackage

// File: rtl/cpu_instr_decode.sv
// cpu_instr_decode: combinational instruction field split and opcode class flags
module cpu_instr_decode
    import cpu_pkg::*;
#(
    parameter int INSTR_W = INSTR_W_D,
    parameter int OP_W    = OP_W_D,
    parameter int REG_AW  = REG_AW_D
) (
    input  logic [INSTR_W-1:0] instr,
    output logic [OP_W-1:0]    op,
    output logic [REG_AW-1:0]  dest,
    output logic [REG_AW-1:0]  src,
    output logic               is_alu,
    output logic               is_jmp,
    output logic               is_halt,
    output logic               is_nop
);
    assign op      = instr[INSTR_W-1 -: OP_W];
    assign dest    = instr[INSTR_W-OP_W-1 -: REG_AW];
    assign src     = instr[INSTR_W-OP_W-REG_AW-1 -: REG_AW];
    assign is_halt = &op;
    assign is_jmp  = op == {{(OP_W-1){1'b1}}, 1'b0};
    assign is_alu  = op <= OP_W'(OP_MOV);
    assign is_nop  = !(is_alu || is_jmp || is_halt);
endmodule

// File: rtl/cpu_seq_control.sv
// cpu_seq_control: multi-cycle fetch/decode/execute/writeback sequencer owning PC, IR and retire count
module cpu_seq_control
    import cpu_pkg::*;
#(
    parameter int INSTR_W = INSTR_W_D,
    parameter int OP_W    = OP_W_D,
    parameter int REG_AW  = REG_AW_D,
    parameter int PC_W    = PC_W_D,
    parameter int CNT_W   = CNT_W_D
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               imem_valid,
    input  logic [INSTR_W-1:0] imem_data,
    output logic               imem_req,
    output logic [PC_W-1:0]    pc,
    output logic [OP_W-1:0]    alu_op,
    output logic [REG_AW-1:0]  dest_reg,
    output logic [REG_AW-1:0]  source_reg,
    output logic               reg_we,
    output logic               halted,
    output logic [CNT_W-1:0]   retired
);
    state_e              state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [INSTR_W-1:0]  ir_q, ir_d;
    logic [OP_W-1:0]     alu_op_q, alu_op_d;
    logic [REG_AW-1:0]   dest_q, dest_d, src_q, src_d;
    logic [CNT_W-1:0]    retired_q, retired_d;
    logic [OP_W-1:0]     dec_op;
    logic [REG_AW-1:0]   dec_dest, dec_src;
    logic                is_alu, is_jmp, is_halt, is_nop;

    cpu_instr_decode #(
        .INSTR_W(INSTR_W),
        .OP_W   (OP_W),
        .REG_AW (REG_AW)
    ) u_dec (
        .instr  (ir_q),
        .op     (dec_op),
        .dest   (dec_dest),
        .src    (dec_src),
        .is_alu (is_alu),
        .is_jmp (is_jmp),
        .is_halt(is_halt),
        .is_nop (is_nop)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        alu_op_d  = alu_op_q;
        dest_d    = dest_q;
        src_d     = src_q;
        retired_d = retired_q;
        case (state_q)
            IDLE:      state_d = start ? FETCH : IDLE;
            FETCH: begin
                if (imem_valid) begin
                    ir_d    = imem_data;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                alu_op_d = dec_op;
                dest_d   = dec_dest;
                src_d    = dec_src;
                state_d  = EXECUTE;
            end
            EXECUTE: begin
                if (is_alu) begin
                    state_d = WRITEBACK;
                end else if (is_jmp || is_nop) begin
                    pc_d      = is_jmp ? ir_q[PC_W-1:0] : pc_q + PC_W'(1);
                    retired_d = retired_q + CNT_W'(1);
                    state_d   = FETCH;
                end else begin
                    state_d = HALT;
                end
            end
            WRITEBACK: begin
                pc_d      = pc_q + PC_W'(1);
                retired_d = retired_q + CNT_W'(1);
                state_d   = FETCH;
            end
            HALT:      state_d = HALT;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            ir_q      <= '0;
            alu_op_q  <= '0;
            dest_q    <= '0;
            src_q     <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            alu_op_q  <= alu_op_d;
            dest_q    <= dest_d;
            src_q     <= src_d;
            retired_q <= retired_d;
        end
    end

    assign imem_req   = state_q == FETCH;
    assign reg_we     = state_q == WRITEBACK;
    assign halted     = state_q == HALT;
    assign pc         = pc_q;
    assign alu_op     = alu_op_q;
    assign dest_reg   = dest_q;
    assign source_reg = src_q;
    assign retired    = retired_q;
endmodule
